// File: rtl/bg_frame_streamer_pkg.sv
// Shared types and helpers for the background frame streamer.
package bg_frame_streamer_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } state_e;

    // Bit width needed to index n items; never below one bit.
    function automatic int unsigned width_of(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // First ROM word of frame sel; frames are stored back to back.
    function automatic int unsigned frame_base(input int unsigned sel,
                                               input int unsigned img_w,
                                               input int unsigned img_h);
        return sel * img_w * img_h;
    endfunction

endpackage

// File: rtl/bg_frame_streamer_rom.sv
// Frame store: synchronous ROM with a registered address and an unregistered
// output, so a word appears one clock after its address is presented.
// The stored image is the word-equals-address test pattern; an empty
// INIT_FILE gives a blank ROM.
module image_rom #(
    parameter int unsigned PIX_W     = 9,
    parameter int unsigned ADDR_W    = 18,
    parameter int unsigned DEPTH     = 153600,
    parameter string       INIT_FILE = "bmp_320_9.mif"
) (
    input  logic              clk_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [PIX_W-1:0]  q_o
);

    localparam bit HasImage = (INIT_FILE != "");

    logic [ADDR_W-1:0] addr_q;

    // Address register: the only clocked element of the ROM.
    always_ff @(posedge clk_i) begin
        addr_q <= addr_i;
    end

    // Word lookup; addresses beyond the stored frames read as zero.
    always_comb begin
        q_o = '0;
        if (HasImage && (32'(addr_q) < DEPTH)) begin
            q_o = PIX_W'(addr_q);
        end
    end

endmodule

// File: rtl/bg_frame_streamer.sv
// Streams one stored frame in raster order over a valid/ready pixel port.
// Reads are issued only while FIFO occupancy plus the in-flight read stays
// below two, so backpressure never overflows the 2-entry output FIFO.
module bg_frame_streamer
    import bg_frame_streamer_pkg::*;
#(
    parameter int unsigned IMG_W      = 320,
    parameter int unsigned IMG_H      = 240,
    parameter int unsigned PIX_W      = 9,
    parameter int unsigned NUM_IMAGES = 2,
    parameter string       INIT_FILE  = "bmp_320_9.mif",
    localparam int unsigned ADDR_W    = width_of(NUM_IMAGES * IMG_W * IMG_H),
    localparam int unsigned X_W       = width_of(IMG_W),
    localparam int unsigned Y_W       = width_of(IMG_H),
    localparam int unsigned SEL_W     = width_of(NUM_IMAGES)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [SEL_W-1:0] img_sel,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic [PIX_W-1:0] pix_color,
    output logic [X_W-1:0]   pix_x,
    output logic [Y_W-1:0]   pix_y,
    output logic             pix_last
);

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic           last;
    } tag_t;

    typedef struct packed {
        logic [PIX_W-1:0] color;
        tag_t             tag;
    } pix_t;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] lin_q, lin_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic              infl_q, infl_d;
    tag_t              infl_tag_q, infl_tag_d;
    logic              err_q, err_d;
    pix_t              mem_q [2];
    pix_t              mem_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        cnt_q, cnt_d;

    logic [ADDR_W-1:0] rom_addr;
    logic [PIX_W-1:0]  rom_q;
    logic              pop;
    logic              at_end;
    logic [2:0]        outstanding;
    pix_t              head;

    assign rom_addr = base_q + lin_q;
    assign at_end   = (x_q == X_W'(IMG_W - 1)) && (y_q == Y_W'(IMG_H - 1));
    assign pop      = pix_valid && pix_ready;
    // A concurrent pop frees a slot this cycle, which keeps ready-high bubble-free.
    assign outstanding = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop};

    image_rom #(
        .PIX_W    (PIX_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (NUM_IMAGES * IMG_W * IMG_H),
        .INIT_FILE(INIT_FILE)
    ) u_rom (
        .clk_i (clock),
        .addr_i(rom_addr),
        .q_o   (rom_q)
    );

    // Next-state: FSM, raster counters, read issue and FIFO bookkeeping.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        lin_d      = lin_q;
        x_d        = x_q;
        y_d        = y_q;
        infl_d     = 1'b0;
        infl_tag_d = infl_tag_q;
        err_d      = 1'b0;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        done       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (32'(img_sel) < NUM_IMAGES) begin
                        base_d  = ADDR_W'(frame_base(32'(img_sel), IMG_W, IMG_H));
                        lin_d   = '0;
                        x_d     = '0;
                        y_d     = '0;
                        state_d = StRun;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (outstanding < 3'd2) begin
                    infl_d     = 1'b1;
                    infl_tag_d = '{x: x_q, y: y_q, last: at_end};
                    lin_d      = lin_q + ADDR_W'(1);
                    if (x_q == X_W'(IMG_W - 1)) begin
                        x_d = '0;
                        y_d = y_q + Y_W'(1);
                    end else begin
                        x_d = x_q + X_W'(1);
                    end
                    if (at_end) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if ((cnt_q == 2'd0) && !infl_q) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // The ROM word for last cycle's read lands in the FIFO now.
        if (infl_q) begin
            mem_d[wr_ptr_q] = '{color: rom_q, tag: infl_tag_q};
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        cnt_d = cnt_q + {1'b0, infl_q} - {1'b0, pop};

        // Abort wins over any transfer, issue or completion this cycle.
        if (abort && (state_q != StIdle)) begin
            state_d  = StIdle;
            infl_d   = 1'b0;
            cnt_d    = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            done     = 1'b0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            base_q     <= '0;
            lin_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            infl_q     <= 1'b0;
            infl_tag_q <= '0;
            err_q      <= 1'b0;
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            cnt_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            lin_q      <= lin_d;
            x_q        <= x_d;
            y_q        <= y_d;
            infl_q     <= infl_d;
            infl_tag_q <= infl_tag_d;
            err_q      <= err_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    // Output port driven from the FIFO head; zeroed while nothing is valid.
    always_comb begin
        head      = mem_q[rd_ptr_q];
        pix_valid = (cnt_q != 2'd0);
        pix_color = pix_valid ? head.color : '0;
        pix_x     = pix_valid ? head.tag.x : '0;
        pix_y     = pix_valid ? head.tag.y : '0;
        pix_last  = pix_valid && head.tag.last;
        busy      = (state_q != StIdle);
        err       = err_q;
    end

endmodule

// File: doc/bg_frame_streamer.md
Name: bg_frame_streamer

Overview:
- Parametrised successor to the fixed 320x240x9 background ROM.
- Holds NUM_IMAGES stored frames of IMG_W x IMG_H pixels, PIX_W bits each, in one synchronous ROM.
- On a start command, streams the selected frame in raster order over a valid/ready pixel interface, tagging each pixel with x, y and last.
- Sits between the frame store and the VGA pixel writer, so the writer can apply backpressure without losing pixels.

Parameters:
- IMG_W, 320, frame width in pixels
- IMG_H, 240, frame height in pixels
- PIX_W, 9, colour bits per pixel
- NUM_IMAGES, 2, number of frames stored back to back (frame k at base k*IMG_W*IMG_H)
- INIT_FILE, "bmp_320_9.mif", ROM initialisation file
- ADDR_W, clog2(NUM_IMAGES*IMG_W*IMG_H), ROM address width (derived)

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to stream a frame
- img_sel  in  clog2(NUM_IMAGES) (min 1)  frame index, sampled with start
- abort  in  1  synchronous cancel of the stream in progress
- busy  out  1  high from start acceptance until done or abort
- done  out  1  one-cycle pulse after the last pixel is accepted downstream
- err  out  1  one-cycle pulse when start carries an out-of-range img_sel
- pix_valid  out  1  output pixel valid
- pix_ready  in  1  downstream accepts the pixel
- pix_color  out  PIX_W  pixel colour
- pix_x  out  clog2(IMG_W)  pixel column
- pix_y  out  clog2(IMG_H)  pixel row
- pix_last  out  1  high with the final pixel of the frame

Behaviour:
- Reset (async, active-high): state IDLE; outputs busy, done, err, pix_valid, pix_last = 0; pix_color, pix_x, pix_y = 0; buffer empty; in-flight flag clear.
- State IDLE:
  - start=1 with img_sel<NUM_IMAGES: latch base = img_sel*IMG_W*IMG_H, clear x/y/linear counters, go to RUN, busy=1 from the next cycle.
  - start=1 with img_sel>=NUM_IMAGES: err pulses for one cycle; state stays IDLE.
- State RUN:
  - A read is issued in a cycle iff (buffer occupancy + in-flight) < 2.
  - Issue = present address base+lin to the ROM, record (x, y, last) in the in-flight slot, then advance the counters.
  - Counter advance: x wraps from IMG_W-1 to 0 and increments y. lin increments by one; no multiplier in the address path.
  - Issuing the read with x=IMG_W-1 and y=IMG_H-1 sets last and moves to DRAIN.
- ROM latency is one clock: address registered at edge N, q valid after edge N. At edge N+1 q and its tags are written into a 2-entry FIFO.
- Output side:
  - pix_* come from the FIFO head.
  - A pixel transfers on any edge where pix_valid && pix_ready.
  - pix_valid and data stay stable while pix_ready=0.
- Latency and throughput:
  - Start sampled at edge 0; first pix_valid rises after edge 2.
  - With pix_ready held high, throughput is one pixel per clock, with no bubbles after the first pixel.
- State DRAIN: no new issues. When the FIFO is empty, nothing is in flight and the last pixel has transferred: done=1 for one cycle, busy drops, go to IDLE.
- Simultaneous events:
  - The FIFO may be written and read in the same cycle; occupancy is unchanged.
  - Full FIFO with pix_ready=0 stalls issue with no loss and no duplicate.
- Start while busy: ignored, no err, current stream unaffected.
- abort (any non-IDLE state):
  - Next edge: flush FIFO, clear in-flight, pix_valid=0, go to IDLE, busy=0.
  - done is not pulsed.
  - abort has priority over a simultaneous transfer or start.
- Frame of one pixel (IMG_W=IMG_H=1): the first issue goes straight to DRAIN; pix_last is set on the only pixel.
- pix_last is asserted only on pixel (IMG_W-1, IMG_H-1).

Decomposition:
- Shared constants header: derived widths (ADDR_W, X_W, Y_W, SEL_W), state encodings IDLE/RUN/DRAIN, and frame base computed as a constant function.
- One sub-module, image_rom: altsyncram in ROM mode, parametrised on PIX_W, ADDR_W, depth and INIT_FILE, with unregistered output (1-clock latency).
- FIFO, counters and FSM live in bg_frame_streamer.

Test Plan (bench params IMG_W=4, IMG_H=3, NUM_IMAGES=2, PIX_W=9; MIF word value = address):
- Frame 0, pix_ready=1: start, img_sel=0 at edge 0 -> pix_valid after edge 2; 12 consecutive pixels colour 0..11; (x,y) run (0,0)..(3,2); pix_last only on colour 11; done one cycle after the last transfer; busy low afterwards.
- Frame 1: img_sel=1 -> colours 12..23 with identical x/y sequence.
- Backpressure: pix_ready random at 30% duty, then held low 10 cycles mid-frame -> outputs stable while stalled; all 12 pixels delivered in order exactly once; no more than 2 reads outstanding.
- Out-of-range select: img_sel=2 (SEL_W=1 so use NUM_IMAGES=3 build, img_sel=3) -> err pulse, busy stays 0, no pix_valid.
- Abort after pixel 5 accepted -> pix_valid=0 and busy=0 on next edge, no done; a following start img_sel=0 restarts cleanly at colour 0.
- Async reset asserted mid-frame, between edges -> all outputs 0 immediately; start after reset release streams a full correct frame.
